// File: rtl/ghost_wall_probe.sv
// Per-frame wall probe for one ghost sprite: samples 8 maze ROM points just outside
// the sprite edges and publishes registered up/down/left/right wall flags.
module ghost_wall_probe #(
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int TILE_W      = 17,
  parameter int TILE_H      = 15,
  parameter int MAZE_COLS   = 28,
  parameter int MAZE_ROWS   = 31,
  parameter int ROM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] ghost_x,
  input  logic [9:0] ghost_y,
  output logic [9:0] maze_addr,
  input  logic       maze_wall,
  output logic       ghost_up_wall,
  output logic       ghost_down_wall,
  output logic       ghost_left_wall,
  output logic       ghost_right_wall,
  output logic       busy,
  output logic       done
);

  localparam int WCW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(ROM_LATENCY - 1);

  localparam logic signed [10:0] NEG1 = -11'sd1;
  localparam logic signed [10:0] OFF_W = 11'(SPRITE_W);
  localparam logic signed [10:0] OFF_WM1 = 11'(SPRITE_W - 1);
  localparam logic signed [10:0] OFF_H = 11'(SPRITE_H);
  localparam logic signed [10:0] OFF_HM1 = 11'(SPRITE_H - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

  state_t           state, state_nxt;
  logic [9:0]       lat_x, lat_y;
  logic [2:0]       probe;
  logic [WCW-1:0]   wait_cnt;
  logic [3:0]       acc;        // {up, down, left, right}
  logic [3:0]       flags;
  logic signed [10:0] dx, dy, px, py;
  logic [10:0]      col, row;
  logic [9:0]       lin_addr;
  logic             oob, hit, last_wait;
  logic [3:0]       hit_vec;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign last_wait = (state == WAIT) && (wait_cnt == LAST_WAIT);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = ISSUE;
      ISSUE:  state_nxt = WAIT;
      WAIT:   if (last_wait) state_nxt = (probe == 3'd7) ? UPDATE : ISSUE;
      UPDATE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Probe point geometry
  always_comb begin
    dx = '0;
    dy = '0;
    unique case (probe)
      3'd0: begin dx = '0;      dy = NEG1;    end
      3'd1: begin dx = OFF_WM1; dy = NEG1;    end
      3'd2: begin dx = '0;      dy = OFF_H;   end
      3'd3: begin dx = OFF_WM1; dy = OFF_H;   end
      3'd4: begin dx = NEG1;    dy = '0;      end
      3'd5: begin dx = NEG1;    dy = OFF_HM1; end
      3'd6: begin dx = OFF_W;   dy = '0;      end
      3'd7: begin dx = OFF_W;   dy = OFF_HM1; end
      default: begin dx = '0;   dy = '0;      end
    endcase
    px = signed'({1'b0, lat_x}) + dx;
    py = signed'({1'b0, lat_y}) + dy;
  end

  assign col      = unsigned'(px) / 11'(TILE_W);
  assign row      = unsigned'(py) / 11'(TILE_H);
  assign oob      = px[10] || py[10] || (col >= 11'(MAZE_COLS)) || (row >= 11'(MAZE_ROWS));
  assign lin_addr = 10'(row * 11'(MAZE_COLS) + col);
  assign hit      = oob || maze_wall;

  always_comb begin
    hit_vec = '0;
    unique case (probe[2:1])
      2'd0: hit_vec[3] = hit;
      2'd1: hit_vec[2] = hit;
      2'd2: hit_vec[1] = hit;
      2'd3: hit_vec[0] = hit;
      default: hit_vec = '0;
    endcase
  end

  // Sweep datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_x    <= '0;
      lat_y    <= '0;
      probe    <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      flags    <= '1;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          lat_x <= ghost_x;
          lat_y <= ghost_y;
          probe <= '0;
          acc   <= '0;
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (last_wait) begin
            acc   <= acc | hit_vec;
            probe <= probe + 3'd1;
            // Final probe folds straight into the flags so they are valid during UPDATE with done.
            if (probe == 3'd7) flags <= acc | hit_vec;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    maze_addr = '0;
    if ((state == ISSUE || state == WAIT) && !oob) maze_addr = lin_addr;
  end

  assign busy             = (state != IDLE);
  assign done             = (state == UPDATE);
  assign ghost_up_wall    = flags[3];
  assign ghost_down_wall  = flags[2];
  assign ghost_left_wall  = flags[1];
  assign ghost_right_wall = flags[0];

endmodule

// File: tb/tb_ghost_wall_probe.sv
// Scoreboard bench for ghost_wall_probe: instance 0 at ROM_LATENCY=1, instance 1 at 2.
module tb_ghost_wall_probe;

  typedef int addr8_t [8];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start [2];
  logic [9:0] gx [2];
  logic [9:0] gy [2];
  logic       rom_mem [2][1024];

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  int         exp_addr_q [2][$];
  logic [3:0] exp_flag_q [2][$];
  int         exp_k_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g + 1;
    logic [9:0] maze_addr;
    logic       maze_wall;
    logic       up, dn, lf, rt, busy, done;
    logic       rom_pipe [L];
    int         bc = 0;
    int         cur = 0;
    bit         have = 0;

    ghost_wall_probe #(.ROM_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .start(start[g]),
      .ghost_x(gx[g]), .ghost_y(gy[g]),
      .maze_addr(maze_addr), .maze_wall(maze_wall),
      .ghost_up_wall(up), .ghost_down_wall(dn),
      .ghost_left_wall(lf), .ghost_right_wall(rt),
      .busy(busy), .done(done)
    );

    always @(posedge clk) begin
      rom_pipe[0] <= rom_mem[g][maze_addr];
      for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign maze_wall = rom_pipe[L-1];

    // Monitor: checks each held probe address and the flags/latency at done
    always @(negedge clk) begin
      if (reset) begin
        bc = 0;
        have = 0;
      end else begin
        if (busy) begin
          if (bc < 8 * (1 + L)) begin
            if ((bc % (1 + L)) == 0) begin
              have = (exp_addr_q[g].size() > 0);
              if (have) cur = exp_addr_q[g].pop_front();
            end
            if (have) chk($sformatf("addr_l%0d_p%0d", L, bc / (1 + L)), int'(maze_addr), cur);
          end
          bc++;
        end else begin
          bc = 0;
          have = 0;
        end
        if (done) begin
          if (exp_flag_q[g].size() == 0) begin
            chk($sformatf("spurious_done_l%0d", L), 1, 0);
          end else begin
            chk($sformatf("flags_l%0d", L), int'({up, dn, lf, rt}), int'(exp_flag_q[g].pop_front()));
            chk($sformatf("latency_l%0d", L), cyc - exp_k_q[g].pop_front(), 8 * (1 + L));
          end
        end
      end
    end
  end

  task automatic issue(input int g, input logic [9:0] x, input logic [9:0] y,
                       input addr8_t a, input logic [3:0] f, input bit track);
    @(negedge clk);
    gx[g] = x;
    gy[g] = y;
    start[g] = 1'b1;
    if (track) begin
      foreach (a[i]) exp_addr_q[g].push_back(a[i]);
      exp_flag_q[g].push_back(f);
      exp_k_q[g].push_back(cyc + 1);
    end
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (exp_flag_q[g].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk($sformatf("drain_timeout_%0d", g), 1, 0);
    repeat (2) @(negedge clk);
  endtask

  addr8_t a_mid   = '{404, 405, 432, 433, 404, 432, 405, 433};
  addr8_t a_org   = '{0, 0, 28, 28, 0, 0, 0, 28};
  addr8_t a_right = '{419, 419, 447, 447, 419, 447, 0, 0};
  addr8_t a_bot   = '{824, 825, 0, 0, 824, 852, 825, 853};

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      gx[g] = '0;
      gy[g] = '0;
      for (int i = 0; i < 1024; i++) rom_mem[g][i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_flags", int'({u[0].up, u[0].dn, u[0].lf, u[0].rt}), 15);
    chk("rst_busy", int'(u[0].busy), 0);
    chk("rst_done", int'(u[0].done), 0);
    chk("rst_addr", int'(u[0].maze_addr), 0);
    chk("rst_flags_l2", int'({u[1].up, u[1].dn, u[1].lf, u[1].rt}), 15);
    reset = 1'b0;
    @(negedge clk);

    // Open maze, mid-field ghost
    issue(0, 10'd209, 10'd222, a_mid, 4'b0000, 1'b1);
    drain(0);

    // Wall tile above-left
    rom_mem[0][404] = 1'b1;
    issue(0, 10'd209, 10'd222, a_mid, 4'b1010, 1'b1);
    drain(0);
    rom_mem[0][404] = 1'b0;

    // Top-left corner: up/left probes out of bounds
    issue(0, 10'd0, 10'd0, a_org, 4'b1010, 1'b1);
    drain(0);
    rom_mem[0][0] = 1'b1;
    issue(0, 10'd0, 10'd0, a_org, 4'b1011, 1'b1);
    drain(0);
    rom_mem[0][0] = 1'b0;

    // Right and bottom maze edges
    issue(0, 10'd460, 10'd222, a_right, 4'b0001, 1'b1);
    drain(0);
    issue(0, 10'd209, 10'd449, a_bot, 4'b0100, 1'b1);
    drain(0);

    // Re-pulsed start and moving ghost mid-sweep are ignored
    rom_mem[0][404] = 1'b1;
    issue(0, 10'd209, 10'd222, a_mid, 4'b1010, 1'b1);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    gx[0] = 10'd300;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!u[0].done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(n < 100), 1);
    // start during UPDATE must not launch a sweep
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("upd_start_busy0", int'(u[0].busy), 0);
    @(negedge clk);
    chk("upd_start_busy1", int'(u[0].busy), 0);
    rom_mem[0][404] = 1'b0;
    drain(0);

    // Reset mid-sweep aborts without done
    issue(0, 10'd209, 10'd222, a_mid, 4'b0000, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_flags", int'({u[0].up, u[0].dn, u[0].lf, u[0].rt}), 15);
    chk("abort_busy", int'(u[0].busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_idle", int'(u[0].busy), 0);
    issue(0, 10'd209, 10'd222, a_mid, 4'b0000, 1'b1);
    drain(0);

    // ROM_LATENCY=2 instance
    rom_mem[1][405] = 1'b1;
    issue(1, 10'd209, 10'd222, a_mid, 4'b1001, 1'b1);
    drain(1);

    chk("queues_empty", exp_addr_q[0].size() + exp_addr_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
